norm2_main: RTL and testbench
=============================

// Module: norm2_main
// PURPOSE
//  Squared-L2-norm accelerator: on-chip signed array plus one MAC loop computing
//  result = init_acc + sum(arr[k]^2), k = init_i .. N-1.
//  The host loads/reads the array through port "a" while controlArr=1.
//  It then pulses r_enable and waits for the one-cycle w_enable done strobe.
// PARAMETERS
//  N       1000  loop bound (exclusive); number of array elements summed
//  ADDR_W  10    array address width; memory depth = 2**ADDR_W (1024)
//  DATA_W  27    signed element width
//  ACC_W   64    signed accumulator/result width
// PORTS
//  clk                  in   1       clock; all logic on rising edge
//  rst                  in   1       synchronous, active-high reset
//  r_enable             in   1       start pulse (sampled only in IDLE with controlArr=0)
//  controlArr           in   1       1: host owns array port a; 0: engine owns it
//  init_i               in   ADDR_W  starting index, latched on start
//  init_acc             in   ACC_W   signed initial accumulator, latched on start
//  controlArrWEnable_a  in   1       host write enable (honoured only when controlArr=1)
//  controlArrAddr_a     in   ADDR_W  host address
//  controlArrWData_a    in   DATA_W  signed host write data
//  controlArrRData_a    out  DATA_W  signed read data, addr registered -> data next cycle
//  w_enable             out  1       done strobe, high exactly one cycle
//  result               out  ACC_W   signed sum; valid while w_enable=1, held until next done
// BEHAVIOUR
//  - Reset: state=IDLE, w_enable=0, result=0, i=0, acc=0. Memory contents are not reset.
//  - Memory: single port, synchronous write, 1-cycle registered read.
//    When controlArr=1, the mux selects host addr/we/wdata.
//    When controlArr=0, the mux selects the engine address; engine never writes.
//  - controlArrRData_a always shows the memory read data, including during engine reads.
//  - FSM: IDLE -> CHECK -> {WAIT -> MAC -> CHECK}* -> DONE -> IDLE.
//    IDLE: if r_enable && !controlArr, then i<=init_i, acc<=init_acc, go CHECK.
//    CHECK: if i >= N, go DONE; else drive addr=i, go WAIT.
//    WAIT: read data becomes valid.
//    MAC: acc <= acc + sext(d*d), with d*d a signed 2*DATA_W product; i <= i+1; go CHECK.
//    DONE: w_enable=1, result=acc; next cycle go IDLE with w_enable=0.
//  - Latency: w_enable rises 3*(N-init_i)+1 rising edges after the edge that samples r_enable.
//    This is 3*max(N-init_i,0)+1 edges; init_i>=N gives 1 edge and result=init_acc.
//  - Arithmetic: the accumulator wraps modulo 2**ACC_W; no saturation or overflow flag.
//  - Ignored: r_enable outside IDLE; r_enable while controlArr=1; host port while controlArr=0.
//  - Host writes to addresses >= N are stored but never summed.
//  - rst mid-operation aborts the run: IDLE, no w_enable; memory keeps its contents.
//  - r_enable in the same cycle as the DONE->IDLE transition is ignored.
//    It is accepted from the following cycle.
// CONFIGURATION
//  NORM2_BUSY_OUT_EN defined: adds output port busy (1 bit).
//   busy = (state != IDLE), including DONE; busy is 0 on reset.
//  NORM2_BUSY_OUT_EN undefined: no busy port; all other behaviour is identical.
// STRUCTURE
//  - Package norm2_pkg holds N, ADDR_W, DATA_W, ACC_W.
//    It also holds typedefs addr_t, data_t (signed), acc_t (signed) and the FSM state enum.
//  - Sub-module norm2_ram: 2**ADDR_W x DATA_W single-port sync RAM with registered read.
//  - The top holds the port mux, FSM, index counter, squarer and accumulator.
// TESTING
//  - Load arr[k]=k-500 for k=0..999, then init_i=0, init_acc=0, start.
//    Expect result=83,333,500 and w_enable at edge 3001.
//  - Load all arr=-2**26, init_i=0, start.
//    Expect result = 1000*2**52 = 4,503,599,627,370,496,000, exactly 1000*(2**26)**2.
//  - init_i=999, init_acc=-5, arr[999]=3: expect result=4, w_enable after 4 edges.
//  - init_i=1000, init_acc=123: expect result=123 one edge after start, w_enable for 1 cycle.
//  - Host write 0x7FFFFF to addr 7, then read addr 7: rdata=0x7FFFFF one cycle later.
//    r_enable with controlArr=1 must produce no w_enable.
//  - Start a run and assert rst at cycle 50: no w_enable, result=0, memory unchanged.
//    A restart gives the correct sum.

Source files
------------

// File: rtl/norm2_pkg.sv
// Shared parameters, types and helpers for the squared-L2-norm accelerator.
`timescale 1ns/1ps
package norm2_pkg;
    localparam int N      = 1000;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 27;
    localparam int ACC_W  = 64;

    typedef logic        [ADDR_W-1:0] addr_t;
    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    localparam addr_t N_A = addr_t'(N);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WAIT, S_MAC, S_DONE} state_t;

    typedef struct packed {
        logic  we;
        addr_t addr;
        data_t wdata;
    } mem_req_t;

    // Full-width signed square, sign-extended to the accumulator width.
    function automatic acc_t sq_ext(input data_t d);
        logic signed [2*DATA_W-1:0] p;
        p = d * d;
        return acc_t'(p);
    endfunction
endpackage

// File: rtl/norm2_ram.sv
// Single-port synchronous RAM, read-before-write, one-cycle registered read.
`timescale 1ns/1ps
module norm2_ram
    import norm2_pkg::*;
(
    input  logic                     clk,
    input  mem_req_t                 req,
    output logic signed [DATA_W-1:0] rdata
);
    data_t mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (req.we) mem[req.addr] <= req.wdata;
        rdata <= mem[req.addr];
    end
endmodule

// File: rtl/norm2_main.sv
// Squared-L2-norm engine: host/engine port mux, MAC FSM, index counter, accumulator.
// Optional busy output enabled by defining NORM2_BUSY_OUT_EN.
`timescale 1ns/1ps
module norm2_main
    import norm2_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     r_enable,
    input  logic                     controlArr,
    input  logic        [ADDR_W-1:0] init_i,
    input  logic signed [ACC_W-1:0]  init_acc,
    input  logic                     controlArrWEnable_a,
    input  logic        [ADDR_W-1:0] controlArrAddr_a,
    input  logic signed [DATA_W-1:0] controlArrWData_a,
    output logic signed [DATA_W-1:0] controlArrRData_a,
    output logic                     w_enable,
    output logic signed [ACC_W-1:0]  result
`ifdef NORM2_BUSY_OUT_EN
    ,
    output logic                     busy
`endif
);
    state_t   state;
    addr_t    i;
    acc_t     acc;
    mem_req_t req;

    // Engine only ever reads, and i is stable from CHECK through MAC.
    always_comb begin
        req = '0;
        if (controlArr) begin
            req.we    = controlArrWEnable_a;
            req.addr  = controlArrAddr_a;
            req.wdata = controlArrWData_a;
        end else begin
            req.addr  = i;
        end
    end

    norm2_ram u_ram (
        .clk   (clk),
        .req   (req),
        .rdata (controlArrRData_a)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            w_enable <= 1'b0;
            result   <= '0;
            i        <= '0;
            acc      <= '0;
        end else begin
            w_enable <= 1'b0;
            case (state)
                S_IDLE: if (r_enable && !controlArr) begin
                    i     <= init_i;
                    acc   <= init_acc;
                    state <= S_CHECK;
                end
                S_CHECK: if (i >= N_A) begin
                    w_enable <= 1'b1;
                    result   <= acc;
                    state    <= S_DONE;
                end else begin
                    state    <= S_WAIT;
                end
                S_WAIT:  state <= S_MAC;
                S_MAC: begin
                    acc   <= acc + sq_ext(controlArrRData_a);
                    i     <= i + addr_t'(1);
                    state <= S_CHECK;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef NORM2_BUSY_OUT_EN
    assign busy = (state != S_IDLE);
`endif
endmodule

// File: tb/tb_norm2_main.sv
// Directed + randomized bench for norm2_main against a plain-arithmetic sum model.
`timescale 1ns/1ps
module tb_norm2_main;
    import norm2_pkg::*;

    logic  clk = 1'b0;
    logic  rst, r_enable, controlArr, we;
    addr_t ii_s, addr;
    acc_t  ia_s, result;
    data_t wdata, rdata;
    logic  w_enable;
`ifdef NORM2_BUSY_OUT_EN
    logic  busy;
`endif

    int tests  = 0;
    int failed = 0;
    int model [1024];

    always #5 clk = ~clk;

    norm2_main dut (
        .clk                 (clk),
        .rst                 (rst),
        .r_enable            (r_enable),
        .controlArr          (controlArr),
        .init_i              (ii_s),
        .init_acc            (ia_s),
        .controlArrWEnable_a (we),
        .controlArrAddr_a    (addr),
        .controlArrWData_a   (wdata),
        .controlArrRData_a   (rdata),
        .w_enable            (w_enable),
        .result              (result)
`ifdef NORM2_BUSY_OUT_EN
        ,
        .busy                (busy)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic host_wr(input int a, input int v);
        @(negedge clk);
        controlArr = 1'b1; we = 1'b1; addr = addr_t'(a); wdata = data_t'(v);
        model[a] = v;
    endtask

    task automatic host_rd_chk(input string tag, input int a);
        @(negedge clk);
        controlArr = 1'b1; we = 1'b0; addr = addr_t'(a);
        @(negedge clk);
        chk(tag, 64'(rdata), 64'(longint'(model[a])));
    endtask

    function automatic int rand_s27();
        int r;
        r = int'($urandom);
        return (r <<< 5) >>> 5;
    endfunction

    // Expected sum/latency come straight from the arithmetic definition.
    // Junk host-port writes are driven during the run; they must be ignored.
    task automatic run_check(input string tag, input int ii, input longint ia);
        longint s;
        int     el, lat;
        s = ia;
        for (int k = ii; k < N; k++) s += longint'(model[k]) * longint'(model[k]);
        el = (ii < N) ? 3 * (N - ii) + 1 : 1;
        @(negedge clk);
        controlArr = 1'b0; we = 1'b1; addr = addr_t'($urandom); wdata = data_t'($urandom);
        ii_s = addr_t'(ii); ia_s = ia; r_enable = 1'b1;
        @(negedge clk);
        r_enable = 1'b0; lat = 0;
        while (w_enable !== 1'b1 && lat < el + 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(el));
        chk({tag, "_res"}, result, s);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(w_enable), 64'(0));
        chk({tag, "_hold"}, result, s);
        we = 1'b0;
    endtask

    initial begin
        bit seen;
        rst = 1'b1; r_enable = 1'b0; controlArr = 1'b1; we = 1'b0;
        addr = '0; wdata = '0; ii_s = '0; ia_s = '0;
        repeat (2) @(negedge clk);
        chk("rst_wen", 64'(w_enable), 64'(0));
        chk("rst_res", result, 64'(0));
        rst = 1'b0;

        // Ramp k-500
        for (int k = 0; k < N; k++) host_wr(k, k - 500);
        run_check("ramp", 0, 0);
        chk("ramp_const", result, 64'd83333500);

        // Host write/readback, including an address past the summed range
        host_wr(7, 32'h7FFFFF);
        host_rd_chk("rd7", 7);
        host_wr(1005, -(1 << 26));
        host_rd_chk("rd1005", 1005);

        // Start while host owns the array is ignored
        @(negedge clk);
        controlArr = 1'b1; we = 1'b0; r_enable = 1'b1;
        @(negedge clk);
        r_enable = 1'b0; seen = 1'b0;
        repeat (10) begin @(negedge clk); if (w_enable) seen = 1'b1; end
        chk("host_start_ign", 64'(seen), 64'(0));

        run_check("past_end", 1000, 123);
        chk("past_end_const", result, 64'd123);

        // r_enable during DONE->IDLE ignored, accepted the cycle after
        @(negedge clk);
        controlArr = 1'b0; ii_s = addr_t'(1000); ia_s = 77; r_enable = 1'b1;
        @(negedge clk);
        r_enable = 1'b0;
        @(negedge clk);
        chk("dn_strobe", 64'(w_enable), 64'(1));
        r_enable = 1'b1;
        @(negedge clk);
        chk("dn_idle", 64'(w_enable), 64'(0));
        @(negedge clk);
        chk("dn_ignored", 64'(w_enable), 64'(0));
        r_enable = 1'b0;
        @(negedge clk);
        chk("dn_accepted", 64'(w_enable), 64'(1));
        chk("dn_res", result, 64'd77);

        // All elements at the most negative value
        for (int k = 0; k < N; k++) host_wr(k, -(1 << 26));
        run_check("negmax", 0, 0);
        chk("negmax_const", result, 64'd4503599627370496000);

        host_wr(999, 3);
        run_check("last", 999, -5);
        chk("last_const", result, 64'd4);

        // Reset mid-run aborts; memory survives
        @(negedge clk);
        controlArr = 1'b0; we = 1'b0; ii_s = '0; ia_s = 0; r_enable = 1'b1;
        @(negedge clk);
        r_enable = 1'b0;
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_res", result, 64'(0));
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (w_enable) seen = 1'b1; end
        chk("abort_wen", 64'(seen), 64'(0));
        host_rd_chk("abort_rd0", 0);
        host_rd_chk("abort_rd999", 999);
        run_check("restart", 0, 0);

        // Randomized tails
        repeat (3) begin
            int     ii;
            longint ia;
            ii = int'($urandom_range(940, 1023));
            for (int k = ii; k < 1024; k++) host_wr(k, rand_s27());
            ia = {$urandom, $urandom};
            run_check("rand", ii, ia);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
